// File: rtl/mult_div_unit.sv
// Multicycle signed 32-bit multiply (radix-2 Booth) / divide (restoring) unit.
// Accepts a start pulse, iterates 32 cycles, then loads HI/LO and pulses done.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        MultOrDiv,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        done,
  output logic        ErroDiv
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;

  state_e      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic        op_q, op_d;          // 1 = DIV
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  // Working pair: {P, multiplier} for MULT, {remainder, quotient} for DIV.
  logic [31:0] work_hi_q, work_hi_d;
  logic [31:0] work_lo_q, work_lo_d;
  logic        qm1_q, qm1_d;
  logic [31:0] opnd_q, opnd_d;      // multiplicand, or divisor magnitude
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        erro_q, erro_d;

  logic [31:0] a_mag, b_mag;
  logic [32:0] booth_sum;
  logic [32:0] div_shift, div_trial;
  logic [31:0] quo_fix, rem_fix;

  assign a_mag = A[31] ? (32'd0 - A) : A;
  assign b_mag = B[31] ? (32'd0 - B) : B;

  // The Booth sum needs a 33rd bit: subtracting 0x80000000 overflows 32 bits.
  always_comb begin
    unique case ({work_lo_q[0], qm1_q})
      2'b01:   booth_sum = {work_hi_q[31], work_hi_q} + {opnd_q[31], opnd_q};
      2'b10:   booth_sum = {work_hi_q[31], work_hi_q} - {opnd_q[31], opnd_q};
      default: booth_sum = {work_hi_q[31], work_hi_q};
    endcase
  end

  assign div_shift = {work_hi_q, work_lo_q[31]};
  assign div_trial = div_shift - {1'b0, opnd_q};
  assign quo_fix   = q_neg_q ? (32'd0 - work_lo_q) : work_lo_q;
  assign rem_fix   = r_neg_q ? (32'd0 - work_hi_q) : work_hi_q;

  always_comb begin
    // NOTE: every _d starts as its _q (or a pulse default) so no path leaves it unassigned and no latch is inferred.
    state_d   = state_q;
    count_d   = count_q;
    op_d      = op_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;
    qm1_d     = qm1_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    erro_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (MultOrDiv && (B == 32'd0)) begin
            erro_d = 1'b1;
          end else begin
            op_d      = MultOrDiv;
            count_d   = 5'd0;
            work_hi_d = 32'd0;
            qm1_d     = 1'b0;
            state_d   = RUN;
            if (MultOrDiv) begin
              work_lo_d = a_mag;
              opnd_d    = b_mag;
              q_neg_d   = A[31] ^ B[31];
              r_neg_d   = A[31];
            end else begin
              work_lo_d = B;
              opnd_d    = A;
            end
          end
        end
      end

      RUN: begin
        if (op_q) begin
          work_hi_d = div_trial[32] ? div_shift[31:0] : div_trial[31:0];
          work_lo_d = {work_lo_q[30:0], ~div_trial[32]};
        end else begin
          work_hi_d = booth_sum[32:1];
          work_lo_d = {booth_sum[0], work_lo_q[31:1]};
          qm1_d     = work_lo_q[0];
        end
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) state_d = FINISH;
      end

      FINISH: begin
        hi_d    = op_q ? rem_fix : work_hi_q;
        lo_d    = op_q ? quo_fix : work_lo_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= 5'd0;
      op_q      <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      work_hi_q <= 32'd0;
      work_lo_q <= 32'd0;
      qm1_q     <= 1'b0;
      opnd_q    <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      op_q      <= op_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      work_hi_q <= work_hi_d;
      work_lo_q <= work_lo_d;
      qm1_q     <= qm1_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      erro_q    <= erro_d;
    end
  end

  assign HI      = hi_q;
  assign LO      = lo_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ErroDiv = erro_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed test-plan cases plus random
// MULT/DIV operations checked against a plain-arithmetic reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        mult_or_div;
  logic [31:0] a, b;
  logic [31:0] hi, lo;
  logic        busy, done, erro_div;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .MultOrDiv (mult_or_div),
    .A         (a),
    .B         (b),
    .HI        (hi),
    .LO        (lo),
    .busy      (busy),
    .done      (done),
    .ErroDiv   (erro_div)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns {HI, LO}; 64-bit arithmetic keeps 0x80000000 / -1 well defined.
  function automatic logic [63:0] model(input logic op, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!op) return sx * sy;
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic launch(input logic op, input logic [31:0] x, input logic [31:0] y);
    start       = 1'b1;
    mult_or_div = op;
    a           = x;
    b           = y;
    tick();
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  // Called right after the accepting edge; returns in the done cycle.
  task automatic wait_done(input string tag, input logic [63:0] exp, input int inject_at);
    int cycles   = 0;
    int busy_cnt = 0;
    while (!done && cycles < 100) begin
      if (busy) busy_cnt++;
      if (inject_at != 0 && cycles + 1 == inject_at) begin
        start       = 1'b1;
        mult_or_div = 1'b0;
        a           = $urandom;
        b           = $urandom;
      end else begin
        start = 1'b0;
      end
      tick();
      cycles++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(cycles), 64'd33);
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
    check({tag, "_flags"}, {61'd0, busy, done, erro_div}, 64'b010);
    check({tag, "_result"}, {hi, lo}, exp);
  endtask

  initial begin
    logic        op;
    logic [31:0] x, y;
    int          cnt;

    reset = 1'b1; start = 1'b0; mult_or_div = 1'b0; a = '0; b = '0;
    tick();
    tick();
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_flags", {61'd0, busy, done, erro_div}, 64'd0);
    reset = 1'b0;
    tick();

    launch(1'b0, 32'd7, 32'hFFFFFFFD);
    wait_done("mult_7_m3", 64'hFFFFFFFF_FFFFFFEB, 0);
    tick();
    check("done_single_pulse", {63'd0, done}, 64'd0);

    launch(1'b0, 32'h80000000, 32'h80000000);
    wait_done("mult_min_min", 64'h40000000_00000000, 0);
    tick();

    launch(1'b1, 32'hFFFFFFF9, 32'd2);
    wait_done("div_m7_2", 64'hFFFFFFFF_FFFFFFFD, 0);
    tick();
    launch(1'b1, 32'd7, 32'hFFFFFFFE);
    wait_done("div_7_m2", 64'h00000001_FFFFFFFD, 0);
    tick();
    launch(1'b1, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div_min_m1", 64'h00000000_80000000, 0);
    tick();

    // Preload HI/LO = 0x11111111 / 0x22222222, then divide by zero.
    launch(1'b0, 32'h55555556, 32'h33333333);
    wait_done("mult_preload", 64'h11111111_22222222, 0);
    tick();
    launch(1'b1, 32'd5, 32'd0);
    check("div0_flags", {61'd0, busy, done, erro_div}, 64'b001);
    check("div0_hilo", {hi, lo}, 64'h11111111_22222222);
    tick();
    check("div0_pulse_end", {61'd0, busy, done, erro_div}, 64'd0);
    cnt = 0;
    repeat (5) begin
      tick();
      if (busy || done || erro_div) cnt++;
    end
    check("div0_idle", 64'(cnt), 64'd0);

    // Reset on edge 10 of a MULT.
    launch(1'b0, 32'd3, 32'd4);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_hilo", {hi, lo}, 64'd0);
    check("midreset_flags", {61'd0, busy, done, erro_div}, 64'd0);
    cnt = 0;
    repeat (40) begin
      tick();
      if (done || busy) cnt++;
    end
    check("midreset_no_done", 64'(cnt), 64'd0);
    launch(1'b0, 32'd3, 32'd4);
    wait_done("mult_3_4", 64'h00000000_0000000C, 0);
    tick();

    // Ignored start at edge 5, then back-to-back start held in the done cycle.
    launch(1'b1, 32'd100, 32'd7);
    wait_done("div_100_7", 64'h00000002_0000000E, 5);
    x = 32'hFFFFFF9C;
    y = 32'd9;
    launch(1'b1, x, y);
    check("b2b_accept", {63'd0, busy}, 64'd1);
    wait_done("div_b2b", model(1'b1, x, y), 0);

    for (int i = 0; i < 20; i++) begin
      op = 1'($urandom_range(0, 1));
      x  = $urandom;
      y  = ($urandom_range(0, 3) == 0) ? 32'($signed($urandom_range(0, 18)) - 9) : $urandom;
      if (op && y == 32'd0) y = 32'd1;
      if (i % 2 == 1) tick();
      launch(op, x, y);
      wait_done(op ? "rand_div" : "rand_mult", model(op, x, y), 0);
    end
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multicycle signed multiply/divide unit on the processor datapath. It responds to the control unit's `MultOrDiv` select and a one-cycle `start` request, and iterates for 32 cycles over the A/B register operands. It then loads the HI/LO result registers and pulses `done`. A divide-by-zero is reported back to the control unit on `ErroDiv` instead of running.

## Interface
Parameters:
- none (datapath fixed at 32 bits)

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request pulse; sampled only when busy=0
- MultOrDiv  in  1  0 = MULT, 1 = DIV; sampled with start
- A  in  32  multiplicand / dividend (signed); sampled with start
- B  in  32  multiplier / divisor (signed); sampled with start
- HI  out  32  MULT: product[63:32]; DIV: remainder
- LO  out  32  MULT: product[31:0]; DIV: quotient
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse when HI/LO have just been updated
- ErroDiv  out  1  one-cycle pulse: DIV requested with B == 0

## Operation
- States: IDLE, RUN, FINISH.
- IDLE:
  - start=1 with MultOrDiv=0 → latch A, B, op; clear the partial result; counter=0; go to RUN.
  - start=1 with MultOrDiv=1 and B≠0 → same, as DIV.
  - start=1 with MultOrDiv=1 and B==0 → stay IDLE; ErroDiv=1 next cycle; HI/LO unchanged; done stays 0.
- RUN: one iteration per cycle; counter increments 0..31; after iteration 31, go to FINISH.
  - MULT: radix-2 Booth over a 65-bit {P, multiplier, q-1} register. Arithmetic shift right each step.
  - DIV: restoring division on operand magnitudes. 32-bit remainder, 32-bit quotient, 33-bit trial subtract.
- FINISH: one cycle, then go to IDLE.
  - Load HI/LO with the result; done=1.
  - DIV sign fixup applies before loading:
    - Quotient is negated if sign(A)≠sign(B).
    - Remainder takes the sign of A.
    - Quotient is truncated toward zero.
- Width rules:
  - MULT result is the full 64-bit signed product; no overflow is possible.
  - DIV of 0x80000000 by 0xFFFFFFFF gives LO=0x80000000, HI=0. The quotient wraps and no error is raised.
- start while busy=1 is ignored; the operation in flight is unaffected.
- Operand inputs may change freely after the accepting edge.
- HI/LO hold their value until the next FINISH or reset.

## Timing
- Let E0 be the edge that samples start=1 with busy=0.
  - Iterations occur on edges E1..E32.
  - FINISH occurs on edge E33: HI/LO update, done=1 for the cycle after E33, busy=0 in that same cycle.
- busy is registered: high for the cycles after E0 through E32; low again after E33.
- Back-to-back operation:
  - start held during the done cycle is accepted at E34.
  - Minimum spacing between accepted starts is 34 edges.
- Divide-by-zero: ErroDiv=1 during the cycle after E0 only; busy stays 0.
- done and ErroDiv are never high in the same cycle.
- Reset values, and effect of reset mid-operation:
  - Outputs: HI=0, LO=0, busy=0, done=0, ErroDiv=0.
  - Internal: state=IDLE, counter=0.
  - A reset during RUN/FINISH discards the partial result; no done is produced.
- reset has priority over start on the same edge.

## Test plan
- MULT, A=7, B=0xFFFFFFFD (−3) → done exactly 33 edges after acceptance; HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy high for 33 cycles.
- MULT, A=B=0x80000000 → HI=0x40000000, LO=0x00000000.
- DIV, A=0xFFFFFFF9 (−7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then A=7, B=0xFFFFFFFE → LO=0xFFFFFFFD, HI=1. Then A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- DIV, A=5, B=0, with previous HI/LO=0x11111111/0x22222222 → ErroDiv single-cycle pulse; done=0; busy=0; HI/LO unchanged.
- Start MULT 3×4; assert reset on edge 10 → all outputs 0 next cycle, no done. Then start MULT 3×4 → HI=0, LO=12.
- Start DIV 100/7; pulse start with MultOrDiv=0 at edge 5 → ignored; result LO=14, HI=2. Start held in the done cycle → next operation accepted at E34.
